// File: rtl/batter_pkg.sv
// batter_pkg: shared states, one-hot result codes and zone grading for batter_judge.
package batter_pkg;
  typedef enum logic [1:0] {IDLE, TRAVEL, WINDOW, RESULT} state_t;
  localparam logic [4:0] HIT1 = 5'b10000;
  localparam logic [4:0] HIT2 = 5'b01000;
  localparam logic [4:0] HIT3 = 5'b00100;
  localparam logic [4:0] HIT4 = 5'b00010;
  localparam logic [4:0] OUT  = 5'b00001;
  localparam logic [4:0] NONE = 5'b00000;
  function automatic logic [4:0] zone_hit(input logic [2:0] k);
    return (k == 3'd0 || k == 3'd6) ? HIT1 :
           (k == 3'd1 || k == 3'd5) ? HIT2 :
           (k == 3'd2 || k == 3'd4) ? HIT3 : HIT4;
  endfunction
  function automatic int max3(input int a, input int b, input int c);
    return (a > b) ? ((a > c) ? a : c) : ((b > c) ? b : c);
  endfunction
endpackage

// File: rtl/batter_lfsr.sv
// batter_lfsr: 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1) flagging fielded balls when low bits are zero.
module batter_lfsr (
  input  logic clk,
  input  logic rst,
  output logic fielded
);
  logic [7:0] lfsr;
  always_ff @(posedge clk)
    if (rst) lfsr <= 8'h01;
    else lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  assign fielded = lfsr[2:0] == 3'b000;
endmodule

// File: rtl/batter_judge.sv
// batter_judge: pitch -> travel -> 7-zone swing window -> held one-hot result.
// BATTER_RANDOM_EN adds random fielded-ball outs on graded window swings.
module batter_judge
  import batter_pkg::*;
#(
  parameter int PITCH_CYCLES = 50_000_000,
  parameter int ZONE_CYCLES  = 5_000_000,
  parameter int HOLD_CYCLES  = 100_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pitch,
  input  logic       swing,
  output logic [4:0] hitout,
  output logic       result_valid,
  output logic       busy
);
  localparam int CW = $clog2(max3(PITCH_CYCLES, ZONE_CYCLES, HOLD_CYCLES)) + 1;
  state_t state;
  logic [CW-1:0] cnt;
  logic [2:0] zone;
  logic swing_q, swing_edge, fielded;
  logic [4:0] grade;
`ifdef BATTER_RANDOM_EN
  batter_lfsr u_lfsr (.clk(clk), .rst(rst), .fielded(fielded));
`else
  assign fielded = 1'b0;
`endif
  assign swing_edge = swing && !swing_q;
  assign grade = fielded ? OUT : zone_hit(zone);
  // cnt is the single shared down-counter; in WINDOW it counts cycles within the current zone
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      zone <= '0;
      swing_q <= 1'b0;
      hitout <= NONE;
      result_valid <= 1'b0;
      busy <= 1'b0;
    end else begin
      swing_q <= swing;
      result_valid <= 1'b0;
      case (state)
        IDLE:
          if (pitch) begin
            state <= TRAVEL;
            busy <= 1'b1;
            cnt <= CW'(PITCH_CYCLES - 1);
          end
        TRAVEL:
          if (swing_edge) begin
            state <= RESULT;
            hitout <= OUT;
            result_valid <= 1'b1;
            cnt <= CW'(HOLD_CYCLES - 1);
          end else if (cnt == '0) begin
            state <= WINDOW;
            zone <= '0;
            cnt <= CW'(ZONE_CYCLES - 1);
          end else cnt <= cnt - 1'b1;
        WINDOW:
          if (swing_edge || (cnt == '0 && zone == 3'd6)) begin
            state <= RESULT;
            hitout <= swing_edge ? grade : OUT;
            result_valid <= 1'b1;
            cnt <= CW'(HOLD_CYCLES - 1);
          end else if (cnt == '0) begin
            zone <= zone + 3'd1;
            cnt <= CW'(ZONE_CYCLES - 1);
          end else cnt <= cnt - 1'b1;
        RESULT:
          if (cnt == '0) begin
            state <= IDLE;
            hitout <= NONE;
            busy <= 1'b0;
          end else cnt <= cnt - 1'b1;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_batter_judge.sv
// tb_batter_judge: directed and randomized pitch scenarios checked cycle by cycle against an arithmetic timeline model.
module tb_batter_judge;
  localparam int P = 4, Z = 2, H = 3, WEND = P + 7 * Z;
  logic clk = 1'b0, rst = 1'b1, pitch = 1'b0, swing = 1'b0;
  logic [4:0] hitout;
  logic result_valid, busy;
  logic [7:0] lfsr_m;
  int n_checks = 0, n_fail = 0;
  batter_judge #(.PITCH_CYCLES(P), .ZONE_CYCLES(Z), .HOLD_CYCLES(H)) dut (
    .clk(clk), .rst(rst), .pitch(pitch), .swing(swing),
    .hitout(hitout), .result_valid(result_valid), .busy(busy)
  );
  always #5 clk = ~clk;
  always @(posedge clk)
    lfsr_m <= rst ? 8'h01 : {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  // hit index is the distance of the zone from the window edge nearest to it
  function automatic logic [4:0] grade_of(input int w);
    int k;
    k = w / Z;
    k = (k > 3) ? 6 - k : k;
    return 5'b10000 >> k;
  endfunction
  // c: swing pulse cycle (-1 none), held: swing high throughout, r: reset cycle (-1 none), stray: extra pitch cycle
  task automatic scenario(input int c, input bit held, input int r, input int stray);
    bit eff, live, in_res;
    int s, last;
    logic [4:0] code;
    eff = !held && c >= 1 && c <= WEND && (r < 0 || c < r);
    s = eff ? c + 1 : WEND + 1;
    code = 5'b00001;
    last = (r + 1 > s + H - 1) ? r + 1 : s + H - 1;
    for (int n = 0; n <= last; n++) begin
      rst = (n == r);
      pitch = (n == 0) || (r < 0 && n == stray);
      swing = held || (n == c);
      if (eff && n == c && c > P) begin
        code = grade_of(c - P - 1);
`ifdef BATTER_RANDOM_EN
        if (lfsr_m[2:0] == 3'b000) code = 5'b00001;
`endif
      end
      @(negedge clk);
      live = (r < 0 || n <= r);
      in_res = live && n >= s && n <= s + H - 1;
      check("hitout", hitout, in_res ? code : 5'b00000);
      check("result_valid", result_valid, live && n == s);
      check("busy", busy, live && n >= 1 && n <= s + H - 1);
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    pitch = 1'b0;
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("reset_hitout", hitout, 5'b00000);
    check("reset_valid", result_valid, 1'b0);
    check("reset_busy", busy, 1'b0);
    @(posedge clk);
    #1;
    scenario(11, 1'b0, -1, 13);
    scenario(5, 1'b0, -1, -1);
    scenario(18, 1'b0, -1, -1);
    scenario(3, 1'b0, -1, -1);
    scenario(-1, 1'b1, -1, -1);
    scenario(11, 1'b0, 8, -1);
    scenario(-1, 1'b0, -1, 7);
    repeat (80) begin
      int c, r, st;
      bit held;
      held = $urandom_range(0, 5) == 0;
      c = held || $urandom_range(0, 7) == 0 ? -1 : int'($urandom_range(0, WEND + H));
      r = $urandom_range(0, 4) == 0 ? int'($urandom_range(1, WEND)) : -1;
      st = $urandom_range(0, 1) == 1 ? int'($urandom_range(1, WEND + H)) : -1;
      scenario(c, held, r, st);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/batter_judge.md
# batter_judge

Swing-timing judge for the baseball game. A pitch request starts a ball-travel phase, then a timed hitting window. The batter's swing edge is graded by where it falls in that window. The result is driven as a one-hot `hitout` code (hit1, hit2, hit3, hit4, out) straight into the batter 7-segment LED decoder, and held for a fixed display time.

## Interface
Parameters:
- `PITCH_CYCLES`, default 50_000_000: ball travel cycles before the window opens; must be ≥1.
- `ZONE_CYCLES`, default 5_000_000: cycles per window zone; the window is 7 zones; must be ≥1.
- `HOLD_CYCLES`, default 100_000_000: cycles the result is held on `hitout`; must be ≥1.

Ports:
- `clk`  in  1  system clock; one clock domain.
- `rst`  in  1  reset, synchronous, active-high.
- `pitch`  in  1  start request; sampled only in IDLE.
- `swing`  in  1  batter button level, already synchronized and debounced; the block edge-detects it.
- `hitout`  out  5  one-hot result {hit1,hit2,hit3,hit4,out}; 0 when no result is shown.
- `result_valid`  out  1  one-cycle pulse when a result is latched.
- `busy`  out  1  high whenever state ≠ IDLE.

## Operation
- States and transitions:
  - IDLE: `pitch`=1 → TRAVEL.
  - TRAVEL: after PITCH_CYCLES cycles → WINDOW; a swing edge → RESULT(out), early swing.
  - WINDOW: swing edge → RESULT(zone grade); after 7·ZONE_CYCLES cycles with no swing → RESULT(out).
  - RESULT: after HOLD_CYCLES cycles → IDLE.
- Swing edge: `swing`=1 this cycle and registered previous value = 0. Edges in IDLE and RESULT are ignored. A swing already held high when the pitch starts is not an edge.
- Zone grade uses window cycle index w (0-based) and zone k = w / ZONE_CYCLES:
  - k0 → hit1, k1 → hit2, k2 → hit3, k3 → hit4, k4 → hit3, k5 → hit2, k6 → hit1.
  - Implement with a zone counter plus an intra-zone counter. No divider.
- `pitch` outside IDLE is ignored; requests are not queued.
- `hitout` is nonzero only in RESULT, and always exactly one bit set there.
- A single down-counter is shared by all phases. Its width is $clog2 of the maximum of PITCH_CYCLES, ZONE_CYCLES and HOLD_CYCLES, plus 1.

## Timing
- All outputs are registered. Reset values: `hitout`=5'b00000, `result_valid`=0, `busy`=0, state=IDLE, counters=0, swing history=0.
- `pitch` high in IDLE at cycle t:
  - TRAVEL (`busy`=1) covers cycles t+1 .. t+PITCH_CYCLES.
  - WINDOW covers cycles t+PITCH_CYCLES+1 .. t+PITCH_CYCLES+7·ZONE_CYCLES.
- Swing edge detected at cycle c: `hitout` is valid at c+1 .. c+HOLD_CYCLES, `result_valid` is high at c+1 only, and IDLE is reached at c+HOLD_CYCLES+1.
- Window expiry: RESULT(out) starts the cycle after the last window cycle.
- A swing edge on the last window cycle is graded hit1 (zone 6), not a timeout.
- `rst` mid-operation: next cycle is IDLE with all outputs 0. The in-flight result is discarded.

## Configuration
- `BATTER_RANDOM_EN` defined:
  - An 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1) is seeded to 8'h01 on `rst` and steps every cycle.
  - On a graded window swing, if lfsr[2:0]==3'b000 the result is forced to out (fielded ball).
  - Early swings and timeouts are unaffected.
- Undefined: no LFSR; grading is purely deterministic as above.

## Structure
- Shared package `batter_pkg` holds:
  - the state enum: IDLE, TRAVEL, WINDOW, RESULT;
  - one-hot constants HIT1=5'b10000, HIT2=5'b01000, HIT3=5'b00100, HIT4=5'b00010, OUT=5'b00001, NONE=5'b00000;
  - the zone-to-hit lookup as a function.
- One sub-module, `batter_lfsr`, instantiated only under `BATTER_RANDOM_EN`.

## Test plan
Parameters PITCH=4, ZONE=2, HOLD=3; macro off unless stated; pitch pulsed at cycle 0.
- Swing edge at cycle 11 (w=6, zone 3) → `hitout`=5'b00010 for cycles 12–14, `result_valid` at 12, `busy` low at 15.
- Swing edge at cycle 5 (w=0) → 5'b10000. Swing edge at cycle 18 (w=13) → 5'b10000.
- Swing edge at cycle 3 (TRAVEL) → 5'b00001 for cycles 4–6. Swing held high from before cycle 0 with no new edge → timeout: 5'b00001 for cycles 19–21.
- `pitch` pulsed at cycle 13 during RESULT of the first scenario → ignored. A fresh pitch at cycle 15 restarts, with TRAVEL at 16–19.
- `rst` at cycle 8 during WINDOW, then a swing edge at cycle 11 → `hitout` stays 0, `busy`=0 from cycle 9, no `result_valid`.
- Macro on: drive the swing edge on a cycle where the reference LFSR model gives lfsr[2:0]=0 inside zone 3 → 5'b00001. On a nonzero cycle → 5'b00010.
